// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between instruction fetch
// (word reads) and the load/store buffer (byte/half/word loads and stores).
// Multi-byte accesses are serialised one byte per cycle. Conflicts are
// resolved round-robin. Speculative reads abort on rob_clear, and stores
// always run to completion.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h00030000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LR, BUSY_LW} state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  state_t      state;
  logic        last_grant;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic [31:0] base_addr;
  logic [23:0] wdata_hi;
  logic [31:0] rbuf;

  logic        if_elig;
  logic        ls_elig;
  logic        ls_io_blocked;
  logic        grant_if;
  logic        grant_ls;
  logic [2:0]  ls_len;
  logic [31:0] next_addr;
  logic [7:0]  next_byte;
  logic [31:0] assembled;

  // Grant decision, next byte address/data and read-data assembly
  always_comb begin
    ls_len        = (ls_size == 2'b00) ? 3'd1 : (ls_size == 2'b01) ? 3'd2 : 3'd4;
    ls_io_blocked = ls_wr && (ls_addr >= IO_BASE) && io_buffer_full;
    if_elig       = if_req && !if_ready;
    ls_elig       = ls_req && !ls_ready && !ls_io_blocked;
    grant_if      = 1'b0;
    grant_ls      = 1'b0;
    if (state == IDLE && !rob_clear) begin
      if (if_elig && ls_elig) begin
        if (last_grant == GRANT_LS) grant_if = 1'b1;
        else                        grant_ls = 1'b1;
      end else if (if_elig) begin
        grant_if = 1'b1;
      end else if (ls_elig) begin
        grant_ls = 1'b1;
      end
    end

    next_addr = base_addr + {29'd0, cnt} + 32'd1;

    case (cnt)
      3'd0:    next_byte = wdata_hi[7:0];
      3'd1:    next_byte = wdata_hi[15:8];
      default: next_byte = wdata_hi[23:16];
    endcase

    // Byte k-1 arrives on mem_din one cycle after its address was driven
    assembled = rbuf;
    case (cnt)
      3'd1:    assembled[7:0]   = mem_din;
      3'd2:    assembled[15:8]  = mem_din;
      3'd3:    assembled[23:16] = mem_din;
      3'd4:    assembled[31:24] = mem_din;
      default: assembled = rbuf;
    endcase
  end

  // Access sequencer: grants, drives the bus byte by byte, and raises ready pulses
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      last_grant <= GRANT_LS;
      cnt        <= 3'd0;
      len        <= 3'd0;
      base_addr  <= 32'd0;
      wdata_hi   <= 24'd0;
      rbuf       <= 32'd0;
      mem_a      <= 32'd0;
      mem_wr     <= 1'b0;
      mem_dout   <= 8'd0;
      if_ready   <= 1'b0;
      ls_ready   <= 1'b0;
      if_data    <= 32'd0;
      ls_rdata   <= 32'd0;
    end else if (rdy_in) begin
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
      case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          mem_a  <= 32'd0;
          if (grant_if) begin
            state      <= BUSY_IF;
            last_grant <= GRANT_IF;
            base_addr  <= if_addr;
            len        <= 3'd4;
            cnt        <= 3'd0;
            rbuf       <= 32'd0;
            mem_a      <= if_addr;
          end else if (grant_ls) begin
            last_grant <= GRANT_LS;
            base_addr  <= ls_addr;
            len        <= ls_len;
            wdata_hi   <= ls_wdata[31:8];
            cnt        <= 3'd0;
            rbuf       <= 32'd0;
            mem_a      <= ls_addr;
            if (ls_wr) begin
              state    <= BUSY_LW;
              mem_wr   <= 1'b1;
              mem_dout <= ls_wdata[7:0];
            end else begin
              state    <= BUSY_LR;
            end
          end
        end
        BUSY_IF, BUSY_LR: begin
          if (rob_clear) begin
            state  <= IDLE;
            mem_a  <= 32'd0;
            mem_wr <= 1'b0;
          end else begin
            rbuf <= assembled;
            cnt  <= cnt + 3'd1;
            if (cnt == len) begin
              state <= IDLE;
              mem_a <= 32'd0;
              if (state == BUSY_IF) begin
                if_ready <= 1'b1;
                if_data  <= assembled;
              end else begin
                ls_ready <= 1'b1;
                ls_rdata <= assembled;
              end
            end else if ((cnt + 3'd1) < len) begin
              mem_a <= next_addr;
            end else begin
              mem_a <= 32'd0;
            end
          end
        end
        BUSY_LW: begin
          if ((cnt + 3'd1) == len) begin
            state    <= IDLE;
            mem_wr   <= 1'b0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            ls_ready <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            mem_a    <= next_addr;
            mem_dout <= next_byte;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, rob_clear, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_ready;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram [0:262143];
  logic        poke_en = 1'b0;
  logic [17:0] poke_addr = 18'd0;
  logic [7:0]  poke_data = 8'd0;

  always #5 clk = ~clk;

  mem_arbiter #(.IO_BASE(32'h00030000)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata)
  );

  // RAM: registered read, write on mem_wr, preload port for the bench
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task poke(input logic [17:0] a, input logic [7:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    step();
    poke_en   = 1'b0;
  endtask

  task idle_inputs();
    if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; rob_clear = 1'b0;
    rdy_in = 1'b1; io_buffer_full = 1'b0;
  endtask

  task test_reset();
    rst_in = 1'b1;
    idle_inputs();
    if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_size = 2'b00;
    poke(18'h00100, 8'h13); poke(18'h00101, 8'h05);
    poke(18'h00102, 8'h10); poke(18'h00103, 8'h00);
    poke(18'h02002, 8'h00); poke(18'h02003, 8'h00); poke(18'h02004, 8'h5A);
    poke(18'h00040, 8'h9C);
    poke(18'h00200, 8'h11); poke(18'h00201, 8'h22);
    poke(18'h00202, 8'h33); poke(18'h00203, 8'h44);
    poke(18'h00400, 8'hEE); poke(18'h00401, 8'hEE);
    poke(18'h00402, 8'hEE); poke(18'h00403, 8'hEE);
    poke(18'h30000, 8'h00);
    step();
    total++;
    if ({mem_a, mem_wr, mem_dout} !== 41'd0) begin
      bad++; $display("[TB] FAIL reset_bus got a=%h wr=%b dout=%h want all 0", mem_a, mem_wr, mem_dout);
    end
    total++;
    if ({if_ready, ls_ready, if_data, ls_rdata} !== 66'd0) begin
      bad++; $display("[TB] FAIL reset_outs got ifr=%b lsr=%b ifd=%h lsd=%h want all 0", if_ready, ls_ready, if_data, ls_rdata);
    end
    rst_in = 1'b0;
    step();
  endtask

  task test_fetch();
    if_addr = 32'h100;
    if_req  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k <= 4) begin
        total++;
        if (mem_a !== 32'h100 + 32'(k - 1)) begin
          bad++; $display("[TB] FAIL fetch_addr k=%0d got=%h want=%h", k, mem_a, 32'h100 + 32'(k - 1));
        end
      end
      total++;
      if (mem_wr !== 1'b0) begin
        bad++; $display("[TB] FAIL fetch_wr k=%0d got=%b want=0", k, mem_wr);
      end
      total++;
      if (if_ready !== (k == 6)) begin
        bad++; $display("[TB] FAIL fetch_ready k=%0d got=%b want=%b", k, if_ready, (k == 6));
      end
      if (k == 6) begin
        total++;
        if (if_data !== 32'h00100513) begin
          bad++; $display("[TB] FAIL fetch_data got=%h want=00100513", if_data);
        end
        if_req = 1'b0;
      end
    end
    step();
  endtask

  task test_half_store();
    ls_wr = 1'b1; ls_size = 2'b01; ls_addr = 32'h2002; ls_wdata = 32'hAABBCCDD;
    ls_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if (mem_wr !== (k == 1 || k == 2)) begin
        bad++; $display("[TB] FAIL hstore_wr k=%0d got=%b want=%b", k, mem_wr, (k == 1 || k == 2));
      end
      if (k == 1) begin
        total++;
        if ({mem_a, mem_dout} !== {32'h2002, 8'hDD}) begin
          bad++; $display("[TB] FAIL hstore_b0 got a=%h d=%h want a=2002 d=dd", mem_a, mem_dout);
        end
      end
      if (k == 2) begin
        total++;
        if ({mem_a, mem_dout} !== {32'h2003, 8'hCC}) begin
          bad++; $display("[TB] FAIL hstore_b1 got a=%h d=%h want a=2003 d=cc", mem_a, mem_dout);
        end
      end
      total++;
      if (ls_ready !== (k == 3)) begin
        bad++; $display("[TB] FAIL hstore_ready k=%0d got=%b want=%b", k, ls_ready, (k == 3));
      end
      if (k == 3) ls_req = 1'b0;
    end
    total++;
    if ({ram[18'h02004], ram[18'h02003], ram[18'h02002]} !== 24'h5ACCDD) begin
      bad++; $display("[TB] FAIL hstore_ram got=%h want=5accdd", {ram[18'h02004], ram[18'h02003], ram[18'h02002]});
    end
    ls_wr = 1'b0;
    step();
  endtask

  task test_conflict();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    if_addr = 32'h100; if_req = 1'b1;
    ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h40; ls_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) begin
        total++;
        if (mem_a !== 32'h100) begin
          bad++; $display("[TB] FAIL conflict_first got a=%h want=100", mem_a);
        end
      end
      total++;
      if (if_ready !== (k == 6)) begin
        bad++; $display("[TB] FAIL conflict_ifready k=%0d got=%b want=%b", k, if_ready, (k == 6));
      end
      total++;
      if (ls_ready !== (k == 9)) begin
        bad++; $display("[TB] FAIL conflict_lsready k=%0d got=%b want=%b", k, ls_ready, (k == 9));
      end
      if (k == 6) begin
        total++;
        if (if_data !== 32'h00100513) begin
          bad++; $display("[TB] FAIL conflict_ifdata got=%h want=00100513", if_data);
        end
      end
      if (k == 7) begin
        total++;
        if ({mem_a, mem_wr} !== {32'h40, 1'b0}) begin
          bad++; $display("[TB] FAIL conflict_lsaddr got a=%h wr=%b want a=40 wr=0", mem_a, mem_wr);
        end
      end
      if (k == 9) begin
        total++;
        if (ls_rdata !== 32'h0000009C) begin
          bad++; $display("[TB] FAIL conflict_lsdata got=%h want=0000009c", ls_rdata);
        end
        if_req = 1'b0; ls_req = 1'b0;
      end
    end
    step();
  endtask

  task test_io_store();
    if_addr = 32'h100; if_req = 1'b1;
    ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h00000077;
    io_buffer_full = 1'b1; ls_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      total++;
      if (if_ready !== (k == 6 || k == 13)) begin
        bad++; $display("[TB] FAIL io_ifready k=%0d got=%b want=%b", k, if_ready, (k == 6 || k == 13));
      end
      total++;
      if (mem_wr !== (k == 14)) begin
        bad++; $display("[TB] FAIL io_wr k=%0d got=%b want=%b", k, mem_wr, (k == 14));
      end
      if (k == 14) begin
        total++;
        if ({mem_a, mem_dout} !== {32'h30000, 8'h77}) begin
          bad++; $display("[TB] FAIL io_bus got a=%h d=%h want a=30000 d=77", mem_a, mem_dout);
        end
      end
      total++;
      if (ls_ready !== (k == 15)) begin
        bad++; $display("[TB] FAIL io_lsready k=%0d got=%b want=%b", k, ls_ready, (k == 15));
      end
      if (k == 10) io_buffer_full = 1'b0;
      if (k == 13) if_req = 1'b0;
      if (k == 15) ls_req = 1'b0;
    end
    total++;
    if (ram[18'h30000] !== 8'h77) begin
      bad++; $display("[TB] FAIL io_ram got=%h want=77", ram[18'h30000]);
    end
    ls_wr = 1'b0;
    step();
  endtask

  task test_rob_load();
    ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'h200; ls_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) begin
        total++;
        if (mem_a !== 32'h201) begin
          bad++; $display("[TB] FAIL robload_addr got=%h want=201", mem_a);
        end
      end
      if (k == 3) begin
        total++;
        if ({mem_a, mem_wr} !== 33'd0) begin
          bad++; $display("[TB] FAIL robload_idle got a=%h wr=%b want a=0 wr=0", mem_a, mem_wr);
        end
        rob_clear = 1'b0;
      end
      total++;
      if (ls_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL robload_ready k=%0d got=%b want=0", k, ls_ready);
      end
      if (k == 2) begin
        rob_clear = 1'b1;
        ls_req    = 1'b0;
      end
    end
  endtask

  task test_rob_store();
    ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_wdata = 32'h87654321;
    ls_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      total++;
      if (mem_wr !== (k <= 4)) begin
        bad++; $display("[TB] FAIL robstore_wr k=%0d got=%b want=%b", k, mem_wr, (k <= 4));
      end
      total++;
      if (ls_ready !== (k == 5)) begin
        bad++; $display("[TB] FAIL robstore_ready k=%0d got=%b want=%b", k, ls_ready, (k == 5));
      end
      if (k == 2) rob_clear = 1'b1;
      if (k == 4) rob_clear = 1'b0;
      if (k == 5) ls_req = 1'b0;
    end
    total++;
    if ({ram[18'h00303], ram[18'h00302], ram[18'h00301], ram[18'h00300]} !== 32'h87654321) begin
      bad++; $display("[TB] FAIL robstore_ram got=%h want=87654321", {ram[18'h00303], ram[18'h00302], ram[18'h00301], ram[18'h00300]});
    end
    ls_wr = 1'b0;
    step();
  endtask

  task test_pause();
    logic [31:0] exp_a;
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_a = (k <= 4) ? 32'h100 : 32'h100 + 32'(k - 4);
      if (k <= 7) begin
        total++;
        if (mem_a !== exp_a) begin
          bad++; $display("[TB] FAIL pause_addr k=%0d got=%h want=%h", k, mem_a, exp_a);
        end
      end
      total++;
      if (if_ready !== (k == 9)) begin
        bad++; $display("[TB] FAIL pause_ready k=%0d got=%b want=%b", k, if_ready, (k == 9));
      end
      if (k == 9) begin
        total++;
        if (if_data !== 32'h00100513) begin
          bad++; $display("[TB] FAIL pause_data got=%h want=00100513", if_data);
        end
        if_req = 1'b0;
      end
      if (k == 1) rdy_in = 1'b0;
      if (k == 4) rdy_in = 1'b1;
    end
    step();
  endtask

  task test_reset_mid();
    ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h400; ls_wdata = 32'h0A0B0C0D;
    ls_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) begin
        total++;
        if ({mem_a, mem_wr, mem_dout} !== {32'h400, 1'b1, 8'h0D}) begin
          bad++; $display("[TB] FAIL rstmid_first got a=%h wr=%b d=%h want a=400 wr=1 d=0d", mem_a, mem_wr, mem_dout);
        end
      end
      if (k == 3) begin
        total++;
        if ({mem_a, mem_wr, ls_ready} !== 34'd0) begin
          bad++; $display("[TB] FAIL rstmid_bus got a=%h wr=%b lsr=%b want all 0", mem_a, mem_wr, ls_ready);
        end
      end
      if (k == 2) begin
        rst_in = 1'b1;
        ls_req = 1'b0;
      end
    end
    rst_in = 1'b0;
    ls_wr  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if ({ls_ready, mem_wr} !== 2'b00) begin
        bad++; $display("[TB] FAIL rstmid_after k=%0d got lsr=%b wr=%b want 0 0", k, ls_ready, mem_wr);
      end
    end
    total++;
    if ({ram[18'h00403], ram[18'h00402], ram[18'h00401], ram[18'h00400]} !== 32'hEEEE0C0D) begin
      bad++; $display("[TB] FAIL rstmid_ram got=%h want=eeee0c0d", {ram[18'h00403], ram[18'h00402], ram[18'h00401], ram[18'h00400]});
    end
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_size = 2'b00;
    $display("[TB] starting mem_arbiter directed tests");
    test_reset();
    test_fetch();
    test_half_store();
    test_conflict();
    test_io_store();
    test_rob_load();
    test_rob_store();
    test_pause();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
